// File: rtl/router_output_ctrl_if.sv
// Allocation and link-side signal bundle for one router output port.
// The controller connects through the slave modport; the requesting side uses master.
interface router_output_ctrl_if #(
  parameter int unsigned DATA_W = 64
);
  logic                  polarity;
  logic [3:0]            in_req;
  logic [4*DATA_W-1:0]   in_data;
  logic [3:0]            in_gnt;
  logic                  out_ready;
  logic                  out_send;
  logic                  out_vc;
  logic [DATA_W-1:0]     out_data;

  modport master (
    output polarity, in_req, in_data, out_ready,
    input  in_gnt, out_send, out_vc, out_data
  );

  modport slave (
    input  polarity, in_req, in_data, out_ready,
    output in_gnt, out_send, out_vc, out_data
  );
endinterface

// File: rtl/router_output_ctrl.sv
// Output-port controller: round-robin allocation into a 1-flit buffer per VC,
// with VC=polarity filled while VC=~polarity drains to the link.
module router_output_ctrl #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned INIT_PRIO = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  router_output_ctrl_if.slave link,
  output logic [1:0]         buf_full,
  output logic [1:0]         rr_ptr_v0,
  output logic [1:0]         rr_ptr_v1,
  output logic [CNT_W-1:0]   sent_cnt_v0,
  output logic [CNT_W-1:0]   sent_cnt_v1
);

  localparam logic [1:0] PTR_RST = 2'((INIT_PRIO + NUM_IN - 1) % NUM_IN);

  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];
  logic [1:0]        buf_full_q, buf_full_d;
  logic [1:0]        rr_ptr_v0_q, rr_ptr_v0_d;
  logic [1:0]        rr_ptr_v1_q, rr_ptr_v1_d;
  logic [CNT_W-1:0]  sent_cnt_v0_q, sent_cnt_v0_d;
  logic [CNT_W-1:0]  sent_cnt_v1_q, sent_cnt_v1_d;

  logic              p, q;
  logic [1:0]        ptr_p;
  logic [1:0]        win;
  logic              found;
  logic              grant;
  logic              send;
  logic [DATA_W-1:0] sel_data;

  assign p     = link.polarity;
  assign q     = ~link.polarity;
  assign ptr_p = p ? rr_ptr_v1_q : rr_ptr_v0_q;

  // Search from the input after the last winner, wrapping modulo NUM_IN.
  always_comb begin
    int unsigned idx;
    logic [1:0]  idx2;
    found = 1'b0;
    win   = ptr_p;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      idx  = (32'(ptr_p) + k) % NUM_IN;
      idx2 = idx[1:0];
      if (!found && link.in_req[idx2]) begin
        found = 1'b1;
        win   = idx2;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (win == 2'(i)) sel_data = link.in_data[i*DATA_W +: DATA_W];
    end
  end

  assign grant = found && !buf_full_q[p] && !reset;
  assign send  = buf_full_q[q] && link.out_ready && !reset;

  assign link.in_gnt   = grant ? (4'b0001 << win) : '0;
  assign link.out_send = send;
  assign link.out_vc   = q;
  assign link.out_data = (buf_full_q[q] && !reset) ? buf_q[q] : '0;

  always_comb begin
    buf_d         = buf_q;
    buf_full_d    = buf_full_q;
    rr_ptr_v0_d   = rr_ptr_v0_q;
    rr_ptr_v1_d   = rr_ptr_v1_q;
    sent_cnt_v0_d = sent_cnt_v0_q;
    sent_cnt_v1_d = sent_cnt_v1_q;
    if (grant) begin
      buf_d[p]      = sel_data;
      buf_full_d[p] = 1'b1;
      if (p) rr_ptr_v1_d = win;
      else   rr_ptr_v0_d = win;
    end
    // Fill and drain always target opposite buffers, so no set/clear conflict.
    if (send) begin
      buf_full_d[q] = 1'b0;
      if (q) begin
        if (sent_cnt_v1_q != '1) sent_cnt_v1_d = sent_cnt_v1_q + 1'b1;
      end else begin
        if (sent_cnt_v0_q != '1) sent_cnt_v0_d = sent_cnt_v0_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q         <= '{default: '0};
      buf_full_q    <= '0;
      rr_ptr_v0_q   <= PTR_RST;
      rr_ptr_v1_q   <= PTR_RST;
      sent_cnt_v0_q <= '0;
      sent_cnt_v1_q <= '0;
    end else begin
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      rr_ptr_v0_q   <= rr_ptr_v0_d;
      rr_ptr_v1_q   <= rr_ptr_v1_d;
      sent_cnt_v0_q <= sent_cnt_v0_d;
      sent_cnt_v1_q <= sent_cnt_v1_d;
    end
  end

  assign buf_full    = buf_full_q;
  assign rr_ptr_v0   = rr_ptr_v0_q;
  assign rr_ptr_v1   = rr_ptr_v1_q;
  assign sent_cnt_v0 = sent_cnt_v0_q;
  assign sent_cnt_v1 = sent_cnt_v1_q;

endmodule

// File: tb/tb_router_output_ctrl.sv
// Scoreboard bench for router_output_ctrl: granted flits are queued per VC and
// matched against the link output; a reference model tracks grants, pointers and counters.
module tb_router_output_ctrl;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    buf_full;
  logic [1:0]    rr_ptr_v0, rr_ptr_v1;
  logic [CW-1:0] sent_cnt_v0, sent_cnt_v1;

  router_output_ctrl_if #(.DATA_W(DW)) ifc ();

  router_output_ctrl #(
    .DATA_W(DW), .NUM_IN(4), .INIT_PRIO(0), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .link(ifc),
    .buf_full(buf_full), .rr_ptr_v0(rr_ptr_v0), .rr_ptr_v1(rr_ptr_v1),
    .sent_cnt_v0(sent_cnt_v0), .sent_cnt_v1(sent_cnt_v1)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [DW-1:0] sbq0 [$];
  logic [DW-1:0] sbq1 [$];

  logic [1:0]    m_full;
  logic [1:0]    m_ptr [2];
  logic [CW-1:0] m_cnt [2];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = '0;
    m_ptr[0] = 2'd3; m_ptr[1] = 2'd3;
    m_cnt[0] = '0;   m_cnt[1] = '0;
    sbq0.delete(); sbq1.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifc.polarity  = 1'b0;
    ifc.in_req    = 4'b1111;
    ifc.out_ready = 1'b1;
    ifc.in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    check("rst_gnt", ifc.in_gnt, 0);
    check("rst_send", ifc.out_send, 0);
    check("rst_data", ifc.out_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input logic pol, input logic [3:0] req, input logic rdy);
    logic [DW-1:0] d [4];
    logic [3:0]    exp_gnt;
    logic [1:0]    w;
    logic          fnd;
    logic          exp_send;
    logic          qv;
    logic [DW-1:0] head;
    int unsigned   idx;
    for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
    ifc.polarity  = pol;
    ifc.in_req    = req;
    ifc.out_ready = rdy;
    ifc.in_data   = {d[3], d[2], d[1], d[0]};
    @(negedge clk);
    qv  = ~pol;
    fnd = 1'b0; w = 2'd0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = (32'(m_ptr[pol]) + k) % 4;
      if (!fnd && req[idx[1:0]]) begin fnd = 1'b1; w = idx[1:0]; end
    end
    exp_gnt  = (fnd && !m_full[pol]) ? (4'b0001 << w) : 4'b0000;
    exp_send = m_full[qv] & rdy;
    check("gnt", ifc.in_gnt, exp_gnt);
    check("send", ifc.out_send, exp_send);
    check("vc", ifc.out_vc, qv);
    check("buf_full", buf_full, m_full);
    check("ptr_v0", rr_ptr_v0, m_ptr[0]);
    check("ptr_v1", rr_ptr_v1, m_ptr[1]);
    check("cnt_v0", sent_cnt_v0, m_cnt[0]);
    check("cnt_v1", sent_cnt_v1, m_cnt[1]);
    if (m_full[qv]) begin
      if ((qv ? sbq1.size() : sbq0.size()) == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        head = qv ? sbq1[0] : sbq0[0];
        check("data", ifc.out_data, head);
        if (exp_send) begin
          if (qv) void'(sbq1.pop_front());
          else    void'(sbq0.pop_front());
        end
      end
    end else begin
      check("data_idle", ifc.out_data, 0);
    end
    if (exp_gnt != 0) begin
      if (pol) sbq1.push_back(d[w]);
      else     sbq0.push_back(d[w]);
      m_full[pol] = 1'b1;
      m_ptr[pol]  = w;
    end
    if (exp_send) begin
      m_full[qv] = 1'b0;
      if (m_cnt[qv] != '1) m_cnt[qv] = m_cnt[qv] + 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    ifc.polarity = 1'b0; ifc.in_req = '0; ifc.in_data = '0; ifc.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Idle after reset
    check("init_ptr_v0", rr_ptr_v0, 3);
    check("init_ptr_v1", rr_ptr_v1, 3);
    for (int i = 0; i < 3; i++) cycle(i[0], 4'b0000, 1'b1);

    // Full load, polarity toggling from 0
    for (int i = 0; i < 10; i++) cycle(i[0], 4'b1111, 1'b1);

    // Backpressure with both buffers full, then release
    for (int i = 0; i < 2; i++) cycle(i[0], 4'b1111, 1'b1);
    for (int i = 0; i < 6; i++) cycle(i[0], 4'b1111, 1'b0);
    check("stall_full", buf_full, 2'b11);
    for (int i = 0; i < 6; i++) cycle(~i[0], 4'b1111, 1'b1);

    // Single requester only on polarity=1
    for (int i = 0; i < 8; i++) cycle(i[0], i[0] ? 4'b0100 : 4'b0000, 1'b1);
    check("only_ptr_v1", rr_ptr_v1, 2);

    // Saturation of the VC1 counter
    do_reset();
    for (int i = 0; i < 42; i++) cycle(i[0], i[0] ? 4'b1011 : 4'b0000, 1'b1);
    check("sat_v1", sent_cnt_v1, 15);
    check("sat_v0", sent_cnt_v0, 0);

    // Polarity held constant
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0110, 1'b1);

    // Reset with both buffers full
    cycle(1'b0, 4'b1111, 1'b0);
    cycle(1'b1, 4'b1111, 1'b0);
    check("pre_rst_full", buf_full, 2'b11);
    do_reset();
    check("post_rst_full", buf_full, 0);
    check("post_rst_cnt", sent_cnt_v1, 0);
    check("post_rst_ptr", rr_ptr_v0, 3);
    for (int i = 0; i < 4; i++) cycle(i[0], 4'b1001, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
